// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// reg_file_pkg : shared register-file / ALU / writeback constants
// Rev 1.0
// ============================================================================
package reg_file_pkg;

    localparam int          DATA_WIDTH = 64;
    localparam int          ADDR_WIDTH = 5;
    localparam logic [4:0]  ZERO_REG   = 5'd0;

    function automatic int num_regs(input int aw);
        return 1 << aw;
    endfunction

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_read_port.sv
`default_nettype none
// ============================================================================
// reg_file_read_port : index-to-data mux with x0 masking and write bypass
// Rev 1.0
// ============================================================================
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] regs_i [num_regs(ADDR_WIDTH)],
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic w_raddr_zero;
    logic w_hit;

    assign w_raddr_zero = (raddr_i == ADDR_WIDTH'(ZERO_REG));

    // Forwarding is suppressed during reset so both ports read 0 while it is held.
    assign w_hit = BYPASS_EN && rst_n_i && we_i
                   && (waddr_i != ADDR_WIDTH'(ZERO_REG))
                   && (waddr_i == raddr_i);

    always_comb begin
        rdata_o = regs_i[raddr_i];
        if (w_raddr_zero) begin
            rdata_o = '0;
        end else if (w_hit) begin
            rdata_o = wdata_i;
        end
    end

endmodule : reg_file_read_port
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// reg_file : 2**ADDR_WIDTH x DATA_WIDTH integer register file, x0 hardwired 0
// Rev 1.0
// ============================================================================
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int NUM_REGS = num_regs(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic                  w_wr_en;

    assign w_wr_en   = reg_write && (write_reg != ADDR_WIDTH'(ZERO_REG));
    assign w_regs[0] = '0;

    // Entry 0 has no storage; entries 1..N-1 each hold one flop bank.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_store
        logic [DATA_WIDTH-1:0] mem_q;
        logic [DATA_WIDTH-1:0] mem_d;

        assign mem_d = (w_wr_en && (write_reg == ADDR_WIDTH'(i))) ? write_data : mem_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem_q <= '0;
            end else begin
                mem_q <= mem_d;
            end
        end

        assign w_regs[i] = mem_q;
    end

    reg_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS_EN  (BYPASS_EN)
    ) u_rd_port1 (
        .rst_n_i (reset),
        .regs_i  (w_regs),
        .raddr_i (read_reg1),
        .we_i    (reg_write),
        .waddr_i (write_reg),
        .wdata_i (write_data),
        .rdata_o (read_data1)
    );

    reg_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS_EN  (BYPASS_EN)
    ) u_rd_port2 (
        .rst_n_i (reset),
        .regs_i  (w_regs),
        .raddr_i (read_reg2),
        .we_i    (reg_write),
        .waddr_i (write_reg),
        .wdata_i (write_data),
        .rdata_o (read_data2)
    );

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// tb_reg_file : directed self-checking bench, bypass and no-bypass instances
// Rev 1.0
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic        reg_write;
    logic [63:0] rd1_b, rd2_b;
    logic [63:0] rd1_n, rd2_n;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .BYPASS_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (rd1_b),
        .read_data2 (rd2_b)
    );

    reg_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .BYPASS_EN(1'b0)) dut_nb (
        .clk        (clk),
        .reset      (reset),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (rd1_n),
        .read_data2 (rd2_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = a;
        write_data = d;
        @(posedge clk);
        #1;
        reg_write  = 1'b0;
    endtask

    initial begin
        // Reset held with a pending write that would bypass if not suppressed
        reset      = 1'b0;
        reg_write  = 1'b1;
        write_reg  = 5'd1;
        write_data = 64'd5;
        read_reg1  = 5'd1;
        read_reg2  = 5'd31;
        #1;
        chk("rst_rd1_bypass_suppressed", rd1_b, 64'd0);
        chk("rst_rd2", rd2_b, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reg_write = 1'b0;
        reset     = 1'b1;
        #1;
        chk("post_rst_x1", rd1_b, 64'd0);
        chk("post_rst_x31", rd2_b, 64'd0);
        read_reg1 = 5'd2;
        #1;
        chk("post_rst_x2", rd1_b, 64'd0);

        // Operand writes for the ALU
        wr(5'd1, 64'd3);
        wr(5'd2, 64'd2);
        read_reg1 = 5'd1;
        read_reg2 = 5'd2;
        #1;
        chk("x1_eq_3", rd1_b, 64'd3);
        chk("x2_eq_2", rd2_b, 64'd2);
        chk("nb_x1_eq_3", rd1_n, 64'd3);
        chk("nb_x2_eq_2", rd2_n, 64'd2);

        // Bypass versus stored-only read
        wr(5'd3, 64'd7);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd3;
        write_data = 64'd9;
        read_reg1  = 5'd3;
        #1;
        chk("byp_before_edge", rd1_b, 64'd9);
        chk("nobyp_before_edge", rd1_n, 64'd7);
        chk("rd2_unaffected", rd2_b, 64'd2);
        @(posedge clk);
        #1;
        chk("byp_after_edge", rd1_b, 64'd9);
        chk("nobyp_after_edge", rd1_n, 64'd9);
        reg_write = 1'b0;

        // x0 write attempt
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 64'hFFFF_FFFF_FFFF_FFFF;
        read_reg1  = 5'd0;
        read_reg2  = 5'd0;
        #1;
        chk("x0_p1_before", rd1_b, 64'd0);
        chk("x0_p2_before", rd2_b, 64'd0);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        chk("x0_p1_after", rd1_b, 64'd0);
        chk("x0_p2_after_nb", rd2_n, 64'd0);

        // Disabled write leaves x4 untouched
        @(negedge clk);
        reg_write  = 1'b0;
        write_reg  = 5'd4;
        write_data = 64'd5;
        read_reg1  = 5'd4;
        read_reg2  = 5'd4;
        @(posedge clk);
        #1;
        chk("x4_unchanged_p1", rd1_b, 64'd0);
        chk("x4_unchanged_p2", rd2_b, 64'd0);

        // Same register on both ports
        read_reg1 = 5'd1;
        read_reg2 = 5'd1;
        #1;
        chk("both_ports_x1_p1", rd1_b, 64'd3);
        chk("both_ports_x1_p2", rd2_b, 64'd3);

        // Reset asserted mid-cycle against a pending write to x5
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd5;
        write_data = 64'd3;
        read_reg2  = 5'd5;
        #1;
        chk("x5_bypass_pre_reset", rd2_b, 64'd3);
        chk("x1_pre_reset", rd1_b, 64'd3);
        reset = 1'b0;
        #1;
        chk("async_rst_x1", rd1_b, 64'd0);
        chk("async_rst_x5_bypass_off", rd2_b, 64'd0);
        chk("async_rst_x1_nb", rd1_n, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_beats_write", rd2_b, 64'd0);
        @(negedge clk);
        reg_write = 1'b0;
        reset     = 1'b1;
        #1;
        chk("x5_zero_after_release", rd2_b, 64'd0);
        chk("x1_zero_after_release", rd1_b, 64'd0);

        // Rewrite x5 twice with the same value
        wr(5'd5, 64'd3);
        wr(5'd5, 64'd3);
        read_reg1 = 5'd5;
        read_reg2 = 5'd5;
        #1;
        chk("x5_p1", rd1_b, 64'd3);
        chk("x5_p2", rd2_b, 64'd3);
        chk("x5_sub_zero", rd1_b - rd2_b, 64'd0);
        chk("x5_nb", rd1_n, 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_reg_file
`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry × 64-bit integer register file.
- Sits directly upstream of the 64-bit ALU: its two read ports supply data1/data2 operands, and its write port accepts the writeback result.
- Register x0 is hardwired to zero.
- Optional write-to-read bypass lets an instruction read a value written in the same cycle.

Parameters:
- DATA_WIDTH, 64, width of each register and of all data ports.
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH.
- BYPASS_EN, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  system clock; all writes on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all registers.
- read_reg1  in  ADDR_WIDTH  index for read port 1 (ALU data1).
- read_reg2  in  ADDR_WIDTH  index for read port 2 (ALU data2).
- write_reg  in  ADDR_WIDTH  destination index for writeback.
- write_data  in  DATA_WIDTH  writeback value (ALU result or load data).
- reg_write  in  1  write enable.
- read_data1  out  DATA_WIDTH  contents of read_reg1.
- read_data2  out  DATA_WIDTH  contents of read_reg2.

Behaviour:
- Storage: array of 2**ADDR_WIDTH registers, DATA_WIDTH bits each. Entry 0 is never written.
- Reset:
  - reset low clears every entry to 0 immediately, without waiting for clk.
  - While reset is low, writes are ignored and bypass is suppressed, so both read ports return 0.
  - Deassertion is sampled normally; the first write can occur at the first rising clk edge with reset high.
- Write:
  - At posedge clk, if reset high, reg_write = 1 and write_reg != 0, then mem[write_reg] <= write_data. Latency: 1 cycle to storage.
  - reg_write = 0 leaves all entries unchanged.
  - write_reg = 0 is silently dropped.
- Read:
  - Combinational, zero-latency from read_reg*/state to read_data*.
  - read_reg* = 0 always returns 0, regardless of reg_write, write_reg or bypass.
- Bypass (BYPASS_EN = 1):
  - If reset high, reg_write = 1, write_reg != 0 and write_reg == read_regN, then read_dataN = write_data in the same cycle, before the edge.
  - After the edge, the stored value equals write_data, so the output is stable across the edge.
- BYPASS_EN = 0: read_dataN shows the old value until the edge, then the new value.
- Simultaneous events:
  - Both ports may address the same register; both return identical data.
  - A write and two reads in one cycle are all legal.
  - A write to x0 combined with reads of x0 returns 0.
- Reset mid-operation: asserting reset in the same cycle as a pending write wins over the write; the register ends at 0.
- Outputs contain no X once reset has been applied. Indices are always in range because the array is fully populated.

Decomposition:
- Shared package/include: DATA_WIDTH = 64, ADDR_WIDTH = 5, ZERO_REG = 5'd0. The ALU and the downstream writeback mux use the same constants.
- One sub-module, reg_file_read_port: index → data mux plus x0 masking and bypass compare. Instantiated twice; parameters pass through.
- Storage, write logic and reset stay in reg_file.

Test Plan:
1. Reset low, then high. Read x1, x2, x31 → all 0. Assert reset low mid-simulation with no clk edge → outputs drop to 0 immediately.
2. Write x1 = 3, then x2 = 2 on consecutive edges; then read_reg1 = 1, read_reg2 = 2 → read_data1 = 3, read_data2 = 2. These are the operands the ALU turns into add = 5, sub = 1, and = 2, or = 3.
3. Bypass:
   - x3 holds 7; in one cycle drive reg_write = 1, write_reg = 3, write_data = 9, read_reg1 = 3 → read_data1 = 9 before the edge and 9 after it.
   - With BYPASS_EN = 0 → 7 before the edge, 9 after.
4. x0 protection: reg_write = 1, write_reg = 0, write_data = 64'hFFFF_FFFF_FFFF_FFFF; read x0 on both ports before and after the edge → 0.
5. reg_write = 0 with write_reg = 4, write_data = 5 → x4 unchanged (0). Both ports reading x4 → identical values.
6. Write x5 = 3 and assert reset low in the same cycle, before the edge → x5 = 0 after reset releases. Rewrite x5 = 3, then x5 = 3 again (same value) → read_data = 3, ALU sub with x5, x5 yields zero = 1.
